// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared CPU constants and fetch FSM encoding
package fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - instruction-memory request/response bus
interface fetch_ctrl_if;

  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready;
  logic [31:0] im_rdata;

  modport master (output im_req, output im_addr, input im_ready, input im_rdata);
  modport slave  (input im_req, input im_addr, output im_ready, output im_rdata);

endinterface

// File: rtl/fetch_ctrl_redir_sel.sv
// rtl/fetch_ctrl_redir_sel.sv - redirect priority mux: exception, eret, branch
module redir_sel
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
  input  logic        i_exc_req,
  input  logic        i_eret_req,
  input  logic [31:0] i_epc,
  input  logic        i_redir_valid,
  input  logic [31:0] i_redir_pc,
  output logic        o_valid,
  output logic [31:0] o_target
);

  assign o_valid  = i_exc_req | i_eret_req | i_redir_valid;
  assign o_target = i_exc_req  ? EXC_VEC :
                    i_eret_req ? i_epc   : i_redir_pc;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller feeding the IF/ID slot
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                redir_valid,
  input  logic [31:0]         redir_pc,
  input  logic                exc_req,
  input  logic                eret_req,
  input  logic [31:0]         epc,
  fetch_ctrl_if.master        imem,
  output logic                if_valid,
  output logic [31:0]         if_instr,
  output logic [31:0]         if_pc
);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic [31:0]  r_stale_addr, w_stale_nxt;
  logic         r_if_valid, w_if_valid_nxt;
  logic [31:0]  r_if_instr, w_if_instr_nxt;
  logic [31:0]  r_if_pc, w_if_pc_nxt;

  logic         w_redir;
  logic [31:0]  w_target;
  logic         w_slot_free;
  logic         w_issue;
  logic         w_accept;

  redir_sel #(.EXC_VEC(EXC_VEC)) u_redir_sel (
    .i_exc_req    (exc_req),
    .i_eret_req   (eret_req),
    .i_epc        (epc),
    .i_redir_valid(redir_valid),
    .i_redir_pc   (redir_pc),
    .o_valid      (w_redir),
    .o_target     (w_target)
  );

  // A request is only presented when its response could land in the slot,
  // so a buffered instruction is never overwritten under stall.
  assign w_slot_free   = !r_if_valid || !stall;
  assign w_issue       = !reset && ((r_state == ST_DRAIN) || w_slot_free);
  assign w_accept      = w_issue && imem.im_ready && (r_state != ST_DRAIN) && !w_redir;
  assign imem.im_req   = w_issue;
  assign imem.im_addr  = (r_state == ST_DRAIN) ? r_stale_addr : r_pc;

  assign if_valid = r_if_valid;
  assign if_instr = r_if_instr;
  assign if_pc    = r_if_pc;

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_stale_nxt    = r_stale_addr;
    w_if_valid_nxt = r_if_valid;
    w_if_instr_nxt = r_if_instr;
    w_if_pc_nxt    = r_if_pc;

    if (r_if_valid && !stall) begin
      w_if_valid_nxt = 1'b0;
    end

    case (r_state)
      ST_IDLE, ST_REQ: begin
        if (w_redir) begin
          w_pc_nxt       = word_align(w_target);
          w_if_valid_nxt = 1'b0;
          // An unanswered request stays owed to memory at its old address.
          if (w_issue && !imem.im_ready) begin
            w_state_nxt = ST_DRAIN;
            w_stale_nxt = r_pc;
          end else begin
            w_state_nxt = ST_REQ;
          end
        end else if (w_accept) begin
          w_if_valid_nxt = 1'b1;
          w_if_instr_nxt = imem.im_rdata;
          w_if_pc_nxt    = r_pc;
          w_pc_nxt       = r_pc + 32'd4;
          w_state_nxt    = stall ? ST_IDLE : ST_REQ;
        end else if (w_issue) begin
          w_state_nxt = ST_REQ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (w_redir) begin
          w_pc_nxt       = word_align(w_target);
          w_if_valid_nxt = 1'b0;
        end
        if (imem.im_ready) begin
          w_state_nxt = ST_REQ;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_stale_addr <= 32'd0;
      r_if_valid   <= 1'b0;
      r_if_instr   <= 32'd0;
      r_if_pc      <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_stale_addr <= w_stale_nxt;
      r_if_valid   <= w_if_valid_nxt;
      r_if_instr   <= w_if_instr_nxt;
      r_if_pc      <= w_if_pc_nxt;
    end
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning first fetch address after reset.
REQ-002 SHALL have parameter EXC_VEC, default 32'h0000_4180, meaning exception/interrupt handler entry.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  hazard-unit freeze of the IF/ID slot.
REQ-006 SHALL have port redir_valid  input  1  D-stage branch/jump resolved as taken.
REQ-007 SHALL have port redir_pc  input  32  next-PC target from the next-PC logic.
REQ-008 SHALL have ports exc_req (input, 1, take exception) and eret_req (input, 1, return from exception).
REQ-009 SHALL have port epc  input  32  return address for eret.
REQ-010 SHALL have ports im_req (output, 1) and im_addr (output, 32): instruction-memory request and word address.
REQ-011 SHALL have ports im_ready (input, 1) and im_rdata (input, 32): response accepted / data, same cycle.
REQ-012 SHALL have ports if_valid (output, 1), if_instr (output, 32) and if_pc (output, 32): IF/ID slot contents.

Function
REQ-013 SHALL hold a fetch PC register; im_addr = fetch PC with bits [1:0] forced to 0.
REQ-014 SHALL implement states IDLE, REQ, DRAIN.
- IDLE: no request outstanding.
- REQ: im_req=1, address held stable until im_ready.
- DRAIN: im_req=1 on the stale address; response discarded.
REQ-015 SHALL move IDLE->REQ when the slot is free (if_valid=0) or consumed this cycle (if_valid & !stall).
REQ-016 SHALL, in REQ with im_ready=1 and no redirect, load if_instr=im_rdata, if_pc=fetch PC, set if_valid=1, advance fetch PC by 4 (mod 2^32, wrap from 32'hFFFF_FFFC to 0), go to REQ if the slot may accept again next cycle, else IDLE.
REQ-017 SHALL clear if_valid when the slot is consumed and no new response is loaded in that cycle.
REQ-018 SHALL keep if_valid, if_instr and if_pc unchanged while stall=1 and if_valid=1.
REQ-019 SHALL apply redirect priority exc_req > eret_req > redir_valid; target EXC_VEC, epc, redir_pc respectively.
REQ-020 SHALL, on any redirect, load fetch PC with the target and clear if_valid (flush the slot) in the same edge, regardless of stall.
REQ-021 SHALL, on a redirect during REQ without im_ready, go to DRAIN; DRAIN->REQ on im_ready, target fetch starts next cycle.
REQ-022 SHALL, on a redirect in the same cycle as im_ready, discard im_rdata and go to REQ on the target.
REQ-023 SHALL, on a redirect in DRAIN, retarget fetch PC and remain in DRAIN.
REQ-024 SHALL deliver first-fetch latency of one cycle from request to if_valid when im_ready is high in the request cycle.

Reset
REQ-025 SHALL, with reset=1 at a clock edge, set state=IDLE, fetch PC=RESET_PC, if_valid=0, if_instr=0, if_pc=0, im_req=0.
REQ-026 SHALL, on reset mid-request, abandon the outstanding request without draining; any late im_ready is ignored.
REQ-027 SHALL assert im_req for RESET_PC on the first cycle after reset deasserts.

Structure
REQ-028 SHALL place RESET_PC, EXC_VEC defaults and the state encoding in the shared CPU package.
REQ-029 SHALL be one module; the redirect-priority mux is a natural sub-module, redir_sel.

Verification
REQ-030 SHALL cover: reset release, im_ready always 1 -> im_addr 3000, 3004, 3008 on consecutive cycles; if_pc follows one cycle later.
REQ-031 SHALL cover: stall=1 for 3 cycles with if_valid=1 -> if_pc/if_instr frozen, im_req=0 after the first buffered fetch.
REQ-032 SHALL cover: redir_valid with redir_pc=3100 while im_ready=0 for 2 cycles -> DRAIN, stale data dropped, next if_pc=3100.
REQ-033 SHALL cover: exc_req, eret_req and redir_valid together -> fetch PC=4180, if_valid=0 next cycle.
REQ-034 SHALL cover: eret_req with epc=3204 in the same cycle as im_ready -> im_rdata discarded, next fetch 3204.
REQ-035 SHALL cover: reset asserted during REQ -> im_req=0 and fetch PC=3000 next cycle, late im_ready has no effect.
